// File: rtl/da_dct_seq.sv
// Bit-serial distributed-arithmetic DCT coefficient engine.
// Walks the sample bits LSB first and accumulates shifted half-table ROM terms.
module da_dct_seq #(
   parameter int WIDTH = 16,
   parameter int ACC_W = 34
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x0,
   input  logic [WIDTH-1:0] x1,
   input  logic [WIDTH-1:0] x2,
   input  logic [WIDTH-1:0] x3,
   output logic             rom_cs,
   output logic [2:0]       rom_addr,
   input  logic [WIDTH-1:0] rom_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] z_out,
   output logic             busy
);

   localparam int JW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [JW-1:0] J_LAST = JW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                  state_r;
   state_t                  state_s;
   logic [WIDTH-1:0]        x0_r;
   logic [WIDTH-1:0]        x1_r;
   logic [WIDTH-1:0]        x2_r;
   logic [WIDTH-1:0]        x3_r;
   logic [JW-1:0]           j_r;
   logic signed [ACC_W-1:0] acc_r;
   logic signed [ACC_W-1:0] rom_ext_s;
   logic signed [ACC_W-1:0] term_s;
   logic signed [ACC_W-1:0] shifted_s;
   logic signed [ACC_W-1:0] acc_next_s;
   logic                    in_ready_r;
   logic                    busy_r;
   logic                    rom_cs_r;
   logic [2:0]              rom_addr_r;
   logic                    out_valid_r;
   logic [ACC_W-1:0]        z_out_r;

   // Half-table folding: a set x0 bit selects the complemented address.
   function automatic logic [2:0] da_addr(input logic b0, input logic b1,
                                          input logic b2, input logic b3);
      logic [2:0] a;
      a = {b1, b2, b3};
      if (b0) begin
         return ~a;
      end else begin
         return a;
      end
   endfunction

   assign in_ready  = in_ready_r;
   assign busy      = busy_r;
   assign rom_cs    = rom_cs_r;
   assign rom_addr  = rom_addr_r;
   assign out_valid = out_valid_r;
   assign z_out     = z_out_r;

   // Term for the current bit; the sign bit's weight is negative.
   always_comb begin
      rom_ext_s = {{(ACC_W-WIDTH){rom_data[WIDTH-1]}}, rom_data};
      term_s    = rom_ext_s;
      if (x0_r[0]) begin
         term_s = -rom_ext_s;
      end else begin
         term_s = rom_ext_s;
      end
      shifted_s = term_s <<< j_r;
      if (j_r == J_LAST) begin
         acc_next_s = acc_r - shifted_s;
      end else begin
         acc_next_s = acc_r + shifted_s;
      end
   end

   // Next-state decode.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (in_valid) begin
               state_s = RUN;
            end else begin
               state_s = IDLE;
            end
         end
         RUN: begin
            if (j_r == J_LAST) begin
               state_s = DONE;
            end else begin
               state_s = RUN;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_s = IDLE;
            end else begin
               state_s = DONE;
            end
         end
         default: state_s = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Datapath and registered handshake/ROM outputs, decoded from the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         x0_r        <= '0;
         x1_r        <= '0;
         x2_r        <= '0;
         x3_r        <= '0;
         j_r         <= '0;
         acc_r       <= '0;
         z_out_r     <= '0;
         out_valid_r <= 1'b0;
         rom_addr_r  <= 3'd0;
         in_ready_r  <= 1'b1;
         busy_r      <= 1'b0;
         rom_cs_r    <= 1'b0;
      end else begin
         in_ready_r <= (state_s == IDLE);
         busy_r     <= (state_s != IDLE);
         rom_cs_r   <= (state_s == RUN);
         case (state_r)
            IDLE: begin
               if (in_valid) begin
                  x0_r       <= x0;
                  x1_r       <= x1;
                  x2_r       <= x2;
                  x3_r       <= x3;
                  j_r        <= '0;
                  acc_r      <= '0;
                  rom_addr_r <= da_addr(x0[0], x1[0], x2[0], x3[0]);
               end
            end
            RUN: begin
               x0_r  <= {1'b0, x0_r[WIDTH-1:1]};
               x1_r  <= {1'b0, x1_r[WIDTH-1:1]};
               x2_r  <= {1'b0, x2_r[WIDTH-1:1]};
               x3_r  <= {1'b0, x3_r[WIDTH-1:1]};
               j_r   <= j_r + JW'(1);
               acc_r <= acc_next_s;
               if (j_r == J_LAST) begin
                  z_out_r     <= acc_next_s;
                  out_valid_r <= 1'b1;
                  rom_addr_r  <= 3'd0;
               end else begin
                  rom_addr_r  <= da_addr(x0_r[1], x1_r[1], x2_r[1], x3_r[1]);
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_r <= 1'b0;
               end
            end
            default: begin
               out_valid_r <= 1'b0;
               rom_addr_r  <= 3'd0;
            end
         endcase
      end
   end

endmodule
